// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state codes, opcode/funct constants and ALU selectors for the multicycle control unit
package mc_ctrl_pkg;
    typedef enum logic [3:0] {
        RST    = 4'd0,
        FETCH  = 4'd1,
        FWAIT  = 4'd2,
        DECODE = 4'd3,
        EXEC_R = 4'd4,
        WB_R   = 4'd5,
        ADDR   = 4'd6,
        MEM_RD = 4'd7,
        MWAIT  = 4'd8,
        WB_MEM = 4'd9,
        MEM_WR = 4'd10,
        WB_I   = 4'd11,
        BRANCH = 4'd12,
        JUMP   = 4'd13,
        HALT   = 4'd14,
        EXC    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_CMP = 3'b111;

    // 3'b000 marks an unsupported funct
    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        return f == FN_ADD ? ALU_ADD :
               f == FN_SUB ? ALU_SUB :
               f == FN_AND ? ALU_AND :
               f == FN_SLT ? ALU_CMP : 3'b000;
    endfunction
endpackage

// File: rtl/mc_control_fsm_wait.sv
// mc_wait_counter: memory wait-state counter, loaded with MEM_LAT-1 and saturating at 0
//   clk, reset (sync, active-low), load/load_val (reload), dec (count down), done (count is 0)
module mc_wait_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign done = cnt == '0;
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: Moore control FSM for a multicycle MIPS-subset datapath
//   in : clk, reset (sync, active-low), opcode/funct (IR fields), zero/overflow (ALU flags)
//   out: datapath enables and mux selects, estado (state code), halted
//   MC_CTRL_OVF_EXC_EN: when defined, add/sub/addi overflow suppresses the write and traps to EXC
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               overflow,
    output logic               memWriteOrRead,
    output logic               pcControl,
    output logic               iorD,
    output logic               irWrite,
    output logic               writeA,
    output logic               writeB,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [2:0]         aluControl,
    output logic               regAluControl,
    output logic               regDst,
    output logic               regWrite,
    output logic [1:0]         memToReg,
    output logic [1:0]         pcSource,
    output logic [STATE_W-1:0] estado,
    output logic               halted
);
    state_t state, nxt;
    logic   done, ovf_exc, pc_write, pc_write_cond;

    mc_wait_counter #(.W(3)) u_wait (
        .clk      (clk),
        .reset    (reset),
        .load     (state == FETCH || state == MEM_RD),
        .dec      (state == FWAIT || state == MWAIT),
        .load_val (3'(MEM_LAT - 1)),
        .done     (done)
    );

`ifdef MC_CTRL_OVF_EXC_EN
    assign ovf_exc = overflow && (state == WB_I ||
                     (state == WB_R && (funct == FN_ADD || funct == FN_SUB)));
`else
    // overflow has no effect in this build
    assign ovf_exc = overflow & 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset)
            state <= RST;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = FETCH;
        case (state)
            RST:    nxt = FETCH;
            FETCH:  nxt = FWAIT;
            FWAIT:  nxt = done ? DECODE : FWAIT;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:              nxt = EXEC_R;
                    OP_LW, OP_SW, OP_ADDI: nxt = ADDR;
                    OP_BEQ:                nxt = BRANCH;
                    OP_J:                  nxt = JUMP;
                    OP_HALT:               nxt = HALT;
                    default:               nxt = FETCH;
                endcase
            end
            EXEC_R: nxt = funct_alu(funct) != 3'b000 ? WB_R : FETCH;
            WB_R:   nxt = ovf_exc ? EXC : FETCH;
            ADDR:   nxt = opcode == OP_LW ? MEM_RD :
                          opcode == OP_SW ? MEM_WR :
                          opcode == OP_ADDI ? WB_I : FETCH;
            MEM_RD: nxt = MWAIT;
            MWAIT:  nxt = done ? WB_MEM : MWAIT;
            WB_I:   nxt = ovf_exc ? EXC : FETCH;
            HALT:   nxt = HALT;
            default: nxt = FETCH;
        endcase
    end

    always_comb begin
        memWriteOrRead = 1'b0;
        pc_write       = 1'b0;
        pc_write_cond  = 1'b0;
        iorD           = 1'b0;
        irWrite        = 1'b0;
        writeA         = 1'b0;
        writeB         = 1'b0;
        aluSrcA        = 1'b0;
        aluSrcB        = 2'd0;
        aluControl     = 3'b000;
        regAluControl  = 1'b0;
        regDst         = 1'b0;
        regWrite       = 1'b0;
        memToReg       = 2'd0;
        pcSource       = 2'd0;
        halted         = 1'b0;
        case (state)
            FETCH: begin
                aluSrcB    = 2'd1;
                aluControl = ALU_ADD;
                pc_write   = 1'b1;
            end
            FWAIT:  irWrite = done;
            DECODE: begin
                writeA        = 1'b1;
                writeB        = 1'b1;
                aluSrcB       = 2'd3;
                aluControl    = ALU_ADD;
                regAluControl = 1'b1;
            end
            EXEC_R: begin
                aluSrcA       = 1'b1;
                aluControl    = funct_alu(funct);
                regAluControl = 1'b1;
            end
            WB_R: begin
                regDst   = 1'b1;
                regWrite = !ovf_exc;
            end
            ADDR: begin
                aluSrcA       = 1'b1;
                aluSrcB       = 2'd2;
                aluControl    = ALU_ADD;
                regAluControl = 1'b1;
            end
            MEM_RD, MWAIT: iorD = 1'b1;
            WB_MEM: begin
                memToReg = 2'd1;
                regWrite = 1'b1;
            end
            MEM_WR: begin
                iorD           = 1'b1;
                memWriteOrRead = 1'b1;
            end
            WB_I: regWrite = !ovf_exc;
            BRANCH: begin
                aluSrcA       = 1'b1;
                aluControl    = ALU_SUB;
                pc_write_cond = 1'b1;
                pcSource      = 2'd1;
            end
            JUMP: begin
                pcSource = 2'd2;
                pc_write = 1'b1;
            end
            HALT: halted = 1'b1;
            EXC: begin
                pcSource = 2'd3;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcControl = pc_write | (pc_write_cond & zero);
    assign estado    = STATE_W'(state);
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed + random instruction runs on MEM_LAT=1 and MEM_LAT=3 instances against a state-trace model
module tb_mc_control_fsm;
`ifdef MC_CTRL_OVF_EXC_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [5:0] opcode = 6'h00, funct = 6'h00;
    logic zero = 1'b0, overflow = 1'b0;
    int nvec = 0, nerr = 0;

    logic mw_1, pc_1, iord_1, ir_1, wa_1, wb_1, asa_1, rac_1, rd_1, rw_1, h_1;
    logic [1:0] asb_1, mtr_1, ps_1;
    logic [2:0] alu_1;
    logic [3:0] est_1;
    logic mw_3, pc_3, iord_3, ir_3, wa_3, wb_3, asa_3, rac_3, rd_3, rw_3, h_3;
    logic [1:0] asb_3, mtr_3, ps_3;
    logic [2:0] alu_3;
    logic [3:0] est_3;

    always #5 clk = ~clk;

    mc_control_fsm #(.MEM_LAT(1), .STATE_W(4)) d1 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
        .memWriteOrRead(mw_1), .pcControl(pc_1), .iorD(iord_1), .irWrite(ir_1), .writeA(wa_1),
        .writeB(wb_1), .aluSrcA(asa_1), .aluSrcB(asb_1), .aluControl(alu_1), .regAluControl(rac_1),
        .regDst(rd_1), .regWrite(rw_1), .memToReg(mtr_1), .pcSource(ps_1), .estado(est_1), .halted(h_1)
    );

    mc_control_fsm #(.MEM_LAT(3), .STATE_W(4)) d3 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
        .memWriteOrRead(mw_3), .pcControl(pc_3), .iorD(iord_3), .irWrite(ir_3), .writeA(wa_3),
        .writeB(wb_3), .aluSrcA(asa_3), .aluSrcB(asb_3), .aluControl(alu_3), .regAluControl(rac_3),
        .regDst(rd_3), .regWrite(rw_3), .memToReg(mtr_3), .pcSource(ps_3), .estado(est_3), .halted(h_3)
    );

    int seq [2][64];
    int len [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] fn_alu(input logic [5:0] f);
        case (f)
            6'h20: return 3'b001;
            6'h22: return 3'b010;
            6'h24: return 3'b011;
            6'h2A: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    task automatic push(input int i, input int s);
        seq[i][len[i]] = s;
        len[i]++;
    endtask

    // Expected state trace from reset release for one instruction held on opcode/funct
    task automatic gen(input int i, input int lat);
        len[i] = 0;
        push(i, 1);
        repeat (lat) push(i, 2);
        push(i, 3);
        case (opcode)
            6'h00: begin
                push(i, 4);
                if (fn_alu(funct) != 3'b000) begin
                    push(i, 5);
                    if (OVF_EN && overflow && (funct == 6'h20 || funct == 6'h22)) push(i, 15);
                end
            end
            6'h23: begin
                push(i, 6);
                push(i, 7);
                repeat (lat) push(i, 8);
                push(i, 9);
            end
            6'h2B: begin push(i, 6); push(i, 10); end
            6'h08: begin
                push(i, 6);
                push(i, 11);
                if (OVF_EN && overflow) push(i, 15);
            end
            6'h04: push(i, 12);
            6'h02: push(i, 13);
            6'h3F: repeat (20) push(i, 14);
            default: ;
        endcase
        if (opcode != 6'h3F) push(i, 1);
    endtask

    task automatic cyc(input string id, input int st, input int nx, input logic [3:0] est,
                       input logic pc, iord, mw, ir, wa, rw, rd, h,
                       input logic [1:0] mtr, ps, input logic [2:0] alu);
        chk({id, " estado"}, 32'(est), 32'(st));
        chk({id, " pcControl"}, 32'(pc), (st == 1 || st == 13 || st == 15) ? 1 : (st == 12 ? 32'(zero) : 0));
        chk({id, " irWrite"}, 32'(ir), 32'(st == 2 && nx != 2));
        chk({id, " regWrite"}, 32'(rw), 32'((st == 5 || st == 9 || st == 11) && nx != 15));
        chk({id, " regDst"}, 32'(rd), 32'(st == 5));
        chk({id, " memToReg"}, 32'(mtr), 32'(st == 9));
        chk({id, " memWrite"}, 32'(mw), 32'(st == 10));
        chk({id, " iorD"}, 32'(iord), 32'(st == 7 || st == 8 || st == 10));
        chk({id, " halted"}, 32'(h), 32'(st == 14));
        chk({id, " pcSource"}, 32'(ps), st == 12 ? 1 : st == 13 ? 2 : st == 15 ? 3 : 0);
        chk({id, " writeA"}, 32'(wa), 32'(st == 3));
        if (st == 12) chk({id, " aluControl"}, 32'(alu), 32'd2);
        if (st == 4 && fn_alu(funct) != 3'b000) chk({id, " aluControl"}, 32'(alu), 32'(fn_alu(funct)));
    endtask

    // Reset for 2 edges, release, then follow both traces for up to cut cycles (0 = whole trace)
    task automatic run(input logic [5:0] o, input logic [5:0] f, input logic zz, input logic vv, input int cut);
        int maxn;
        @(negedge clk);
        reset = 1'b0;
        opcode = o;
        funct = f;
        zero = zz;
        overflow = vv;
        repeat (2) @(posedge clk);
        #1;
        chk("L1 reset estado", 32'(est_1), 0);
        chk("L3 reset estado", 32'(est_3), 0);
        chk("L1 reset outputs", 32'({mw_1, pc_1, iord_1, ir_1, wa_1, wb_1, asa_1, asb_1, alu_1, rac_1, rd_1, rw_1, mtr_1, ps_1, h_1}), 0);
        chk("L3 reset outputs", 32'({mw_3, pc_3, iord_3, ir_3, wa_3, wb_3, asa_3, asb_3, alu_3, rac_3, rd_3, rw_3, mtr_3, ps_3, h_3}), 0);
        @(negedge clk);
        reset = 1'b1;
        gen(0, 1);
        gen(1, 3);
        maxn = len[0] > len[1] ? len[0] : len[1];
        if (cut > 0 && cut < maxn) maxn = cut;
        for (int k = 0; k < maxn; k++) begin
            @(posedge clk);
            #1;
            if (k < len[0])
                cyc("L1", seq[0][k], k + 1 < len[0] ? seq[0][k + 1] : -1, est_1,
                    pc_1, iord_1, mw_1, ir_1, wa_1, rw_1, rd_1, h_1, mtr_1, ps_1, alu_1);
            if (k < len[1])
                cyc("L3", seq[1][k], k + 1 < len[1] ? seq[1][k + 1] : -1, est_3,
                    pc_3, iord_3, mw_3, ir_3, wa_3, rw_3, rd_3, h_3, mtr_3, ps_3, alu_3);
        end
    endtask

    initial begin
        logic [5:0] ops [7] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h02, 6'h3F};
        logic [5:0] fns [4] = '{6'h20, 6'h22, 6'h24, 6'h2A};
        logic [5:0] o, f;
        run(6'h00, 6'h20, 1'b0, 1'b0, 0);
        run(6'h23, 6'h00, 1'b0, 1'b0, 0);
        run(6'h2B, 6'h00, 1'b1, 1'b0, 0);
        run(6'h08, 6'h00, 1'b0, 1'b0, 0);
        run(6'h04, 6'h00, 1'b0, 1'b0, 0);
        run(6'h04, 6'h00, 1'b1, 1'b0, 0);
        run(6'h02, 6'h00, 1'b0, 1'b0, 0);
        run(6'h11, 6'h20, 1'b0, 1'b0, 0);
        run(6'h00, 6'h3B, 1'b0, 1'b0, 0);
        run(6'h3F, 6'h00, 1'b0, 1'b0, 0);
        run(6'h00, 6'h20, 1'b0, 1'b1, 0);
        run(6'h00, 6'h24, 1'b0, 1'b1, 0);
        run(6'h08, 6'h00, 1'b0, 1'b1, 0);
        run(6'h23, 6'h00, 1'b0, 1'b0, 4);
        run(6'h23, 6'h00, 1'b0, 1'b0, 9);
        for (int n = 0; n < 60; n++) begin
            o = $urandom_range(0, 7) == 7 ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 6)];
            f = $urandom_range(0, 4) == 4 ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 3)];
            run(o, f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0 ? $urandom_range(1, 8) : 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
